multicycle_control: RTL

- Multi-cycle sequencer for the RV32I core. It steps one instruction through fetch, decode, execute, memory and writeback.
- It consumes the instruction decoder's class flags and illegal flag, and drives the instruction-register, register-file, PC and memory strobes.
- It also owns trap entry and the retired-instruction counter.

---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multi-cycle sequencer and the rest of the RV32I core:
// decoder flags, memory acks and halt request in; datapath strobes, trap and status out.
interface multicycle_control_if;
    logic        halt_req;
    logic        imem_ack;
    logic        dmem_ack;
    logic        illegal;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_fence;
    logic        is_ecall;
    logic        is_ebreak;
    logic        branch_taken;

    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap_valid;
    logic [4:0]  trap_cause;
    logic        halted;
    logic [31:0] instret;

    modport master (
        input  halt_req, imem_ack, dmem_ack, illegal, is_load, is_store, is_branch,
               is_jump, is_fence, is_ecall, is_ebreak, branch_taken,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
               trap_valid, trap_cause, halted, instret
    );

    modport slave (
        output halt_req, imem_ack, dmem_ack, illegal, is_load, is_store, is_branch,
               is_jump, is_fence, is_ecall, is_ebreak, branch_taken,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
               trap_valid, trap_cause, halted, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with trap entry and instret.
// Define MEM_TIMEOUT_EN to add a memory-ack watchdog that traps after TIMEOUT_CYCLES waits.
module multicycle_control #(
    parameter logic [4:0] TRAP_ILLEGAL = 5'd2,
    parameter logic [4:0] TRAP_BREAK   = 5'd3,
    parameter logic [4:0] TRAP_ECALL   = 5'd11
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_load, r_store, r_branch, r_jump, r_fence, r_take;
    logic [4:0]  r_trap_cause, w_cause_next;
    logic [31:0] r_instret;
    logic        w_retire;
    logic        w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_rf_we, w_pc_we;
    logic        w_trap_valid, w_halted;
    logic [1:0]  w_pc_sel;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  r_wait_cnt;
    logic        w_waiting;
    logic        w_timeout;

    assign w_waiting = (r_state == S_FETCH && !bus.imem_ack) ||
                       (r_state == S_MEM   && !bus.dmem_ack);
    // An ack in the limit cycle keeps w_waiting low, so the ack wins over the trap.
    assign w_timeout = w_waiting && (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_load       <= 1'b0;
            r_store      <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_fence      <= 1'b0;
            r_take       <= 1'b0;
            r_trap_cause <= '0;
            r_instret    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_trap_cause <= w_cause_next;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (r_state == S_DECODE) begin
                r_load   <= bus.is_load;
                r_store  <= bus.is_store;
                r_branch <= bus.is_branch;
                r_jump   <= bus.is_jump;
                r_fence  <= bus.is_fence;
            end
            if (r_state == S_EXEC) begin
                r_take <= r_jump | (r_branch & bus.branch_taken);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_trap_cause;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_ir_we      = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = 2'd0;
        w_trap_valid = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            S_IDLE: w_state_next = bus.halt_req ? S_HALT : S_FETCH;
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_ir_we      = 1'b1;
                    w_state_next = S_DECODE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_timeout) begin
                    w_cause_next = 5'd1;
                    w_state_next = S_TRAP;
                end
`endif
            end
            S_DECODE: begin
                if (bus.illegal) begin
                    w_cause_next = TRAP_ILLEGAL;
                    w_state_next = S_TRAP;
                end else if (bus.is_ebreak) begin
                    w_cause_next = TRAP_BREAK;
                    w_state_next = S_TRAP;
                end else if (bus.is_ecall) begin
                    w_cause_next = TRAP_ECALL;
                    w_state_next = S_TRAP;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: w_state_next = (r_load | r_store) ? S_MEM : S_WB;
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = r_store;
                // A store retires in its ack cycle, so pc_we rides on the final request beat.
                if (bus.dmem_ack) begin
                    if (r_store) begin
                        w_pc_we      = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_timeout) begin
                    w_cause_next = r_store ? 5'd7 : 5'd5;
                    w_state_next = S_TRAP;
                end
`endif
            end
            S_WB: begin
                w_rf_we      = ~(r_store | r_branch | r_fence);
                w_pc_we      = 1'b1;
                w_pc_sel     = r_take ? 2'd1 : 2'd0;
                w_retire     = 1'b1;
                w_state_next = bus.halt_req ? S_HALT : S_FETCH;
            end
            S_TRAP: begin
                w_trap_valid = 1'b1;
                w_pc_we      = 1'b1;
                w_pc_sel     = 2'd2;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (!bus.halt_req) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.imem_req   = w_imem_req;
    assign bus.ir_we      = w_ir_we;
    assign bus.dmem_req   = w_dmem_req;
    assign bus.dmem_we    = w_dmem_we;
    assign bus.rf_we      = w_rf_we;
    assign bus.pc_we      = w_pc_we;
    assign bus.pc_sel     = w_pc_sel;
    assign bus.trap_valid = w_trap_valid;
    assign bus.trap_cause = r_trap_cause;
    assign bus.halted     = w_halted;
    assign bus.instret    = r_instret;

endmodule
